// File: rtl/mcdt_arbiter.sv
// mcdt_arbiter: arbitration and sequencing stage of the MCDT path.
// Grants one of three channel FIFOs at a time for a packet of up to PKT_LEN
// beats and merges the popped data into one output stream. The winner is the
// highest 2-bit priority among requesters; ties go round-robin, starting after
// the last served channel.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   slvN_req_i                   channel N FIFO non-empty
//   slvN_data_i [DATA_W]         channel N head-of-FIFO data
//   slvN_prio_i [2]              channel N priority (3 = highest)
//   slvN_ack_o                   channel N pop strobe (combinational)
//   mcdt_data_o/val_o/id_o       merged output beat, one cycle after the ack
//   stat_clr_i                   clear per-channel beat counters
//   statN_cnt_o [CNT_W]          beats forwarded from channel N
//
// Optional feature: define MCDT_ARB_STATS_EN to build the saturating
// per-channel beat counters; otherwise the counters read as 0.
module mcdt_arbiter #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned PKT_LEN = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              slv0_req_i,
    input  logic              slv1_req_i,
    input  logic              slv2_req_i,
    input  logic [DATA_W-1:0] slv0_data_i,
    input  logic [DATA_W-1:0] slv1_data_i,
    input  logic [DATA_W-1:0] slv2_data_i,
    input  logic [1:0]        slv0_prio_i,
    input  logic [1:0]        slv1_prio_i,
    input  logic [1:0]        slv2_prio_i,
    output logic              slv0_ack_o,
    output logic              slv1_ack_o,
    output logic              slv2_ack_o,
    output logic [DATA_W-1:0] mcdt_data_o,
    output logic              mcdt_val_o,
    output logic [1:0]        mcdt_id_o,
    input  logic              stat_clr_i,
    output logic [CNT_W-1:0]  stat0_cnt_o,
    output logic [CNT_W-1:0]  stat1_cnt_o,
    output logic [CNT_W-1:0]  stat2_cnt_o
);

    localparam logic [3:0] LAST_BEAT = 4'(PKT_LEN - 1);

    typedef enum logic {S_IDLE, S_XFER} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_grant;
    logic [1:0]        r_last;
    logic [3:0]        r_beat;
    logic [DATA_W-1:0] r_data;
    logic              r_val;
    logic [1:0]        r_id;

    logic [2:0]        w_req;
    logic [1:0]        w_prio [0:2];
    logic [2:0]        w_ack;
    logic [1:0]        w_win;
    logic [1:0]        w_best;
    logic              w_found;
    logic [1:0]        w_idx;
    logic [DATA_W-1:0] w_sel_data;

    assign w_req     = {slv2_req_i, slv1_req_i, slv0_req_i};
    assign w_prio[0] = slv0_prio_i;
    assign w_prio[1] = slv1_prio_i;
    assign w_prio[2] = slv2_prio_i;

    // Channel visited at scan step k, starting just after the last served one.
    function automatic logic [1:0] rr_idx(input logic [1:0] last, input logic [1:0] k);
        logic [2:0] s;
        s = 3'(last) + 3'(k) + 3'd1;
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

    // Winner: strict '>' keeps the earliest channel in round-robin order on ties.
    always_comb begin
        w_win   = 2'd0;
        w_best  = 2'd0;
        w_found = 1'b0;
        w_idx   = 2'd0;
        for (int k = 0; k < 3; k++) begin
            w_idx = rr_idx(r_last, 2'(k));
            if (w_req[w_idx] && (!w_found || (w_prio[w_idx] > w_best))) begin
                w_found = 1'b1;
                w_best  = w_prio[w_idx];
                w_win   = w_idx;
            end
        end
    end

    // Next state and pop strobes; no pop while reset is asserted.
    always_comb begin
        w_state_nxt = r_state;
        w_ack       = 3'b000;
        case (r_state)
            S_IDLE: begin
                if (|w_req) w_state_nxt = S_XFER;
            end
            S_XFER: begin
                w_ack[r_grant] = w_req[r_grant] & ~rst_i;
                if (!w_req[r_grant] || (r_beat == LAST_BEAT)) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        case (r_grant)
            2'd1:    w_sel_data = slv1_data_i;
            2'd2:    w_sel_data = slv2_data_i;
            default: w_sel_data = slv0_data_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Grant bookkeeping and registered output beat.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_grant <= 2'd0;
            r_last  <= 2'd2;
            r_beat  <= 4'd0;
            r_data  <= '0;
            r_val   <= 1'b0;
            r_id    <= 2'd0;
        end else begin
            r_val <= |w_ack;
            if (r_state == S_IDLE && (|w_req)) begin
                r_grant <= w_win;
                r_beat  <= 4'd0;
            end
            if (|w_ack) begin
                r_data <= w_sel_data;
                r_id   <= r_grant;
                r_beat <= r_beat + 4'd1;
            end
            if (r_state == S_XFER && w_state_nxt == S_IDLE) r_last <= r_grant;
        end
    end

    assign slv0_ack_o  = w_ack[0];
    assign slv1_ack_o  = w_ack[1];
    assign slv2_ack_o  = w_ack[2];
    assign mcdt_data_o = r_data;
    assign mcdt_val_o  = r_val;
    assign mcdt_id_o   = r_id;

`ifdef MCDT_ARB_STATS_EN
    logic [CNT_W-1:0] r_stat [0:2];

    // Saturating beat counters; clear wins over a same-cycle pop.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_i || stat_clr_i)             r_stat[i] <= '0;
            else if (w_ack[i] && ~&r_stat[i])    r_stat[i] <= r_stat[i] + CNT_W'(1);
        end
    end

    assign stat0_cnt_o = r_stat[0];
    assign stat1_cnt_o = r_stat[1];
    assign stat2_cnt_o = r_stat[2];
`else
    logic w_unused_clr;
    assign w_unused_clr = stat_clr_i;
    assign stat0_cnt_o  = '0;
    assign stat1_cnt_o  = '0;
    assign stat2_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_mcdt_arbiter.sv
// Bench for mcdt_arbiter: directed table, hand-written corner sequences and
// randomized traffic checked against a packet-level reference model.
module tb_mcdt_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned PL = 4;
    localparam int unsigned CW = 4;
    localparam int unsigned SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req [0:2];
    logic [DW-1:0] din [0:2];
    logic [1:0]    pr  [0:2];
    logic          clr;
    logic          ack0, ack1, ack2;
    logic [DW-1:0] odata;
    logic          oval;
    logic [1:0]    oid;
    logic [CW-1:0] st0, st1, st2;

    always #5 clk = ~clk;

    mcdt_arbiter #(.DATA_W(DW), .PKT_LEN(PL), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst),
        .slv0_req_i(req[0]), .slv1_req_i(req[1]), .slv2_req_i(req[2]),
        .slv0_data_i(din[0]), .slv1_data_i(din[1]), .slv2_data_i(din[2]),
        .slv0_prio_i(pr[0]), .slv1_prio_i(pr[1]), .slv2_prio_i(pr[2]),
        .slv0_ack_o(ack0), .slv1_ack_o(ack1), .slv2_ack_o(ack2),
        .mcdt_data_o(odata), .mcdt_val_o(oval), .mcdt_id_o(oid),
        .stat_clr_i(clr),
        .stat0_cnt_o(st0), .stat1_cnt_o(st1), .stat2_cnt_o(st2)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a packet in flight with a channel and beats done so far.
    bit          m_busy;
    int          m_ch, m_beats, m_last;
    bit          m_val;
    logic [31:0] m_data;
    int          m_id;
    int          m_stat [0:2];

    // Packet start order observed on the DUT acks.
    int       pkt_q [$];
    bit [2:0] prev_ack = 3'b000;

    function automatic int pick();
        int best = -1;
        int win  = 0;
        for (int k = 1; k <= 3; k++) begin
            int c = (m_last + k) % 3;
            if (req[c] && int'(pr[c]) > best) begin
                best = int'(pr[c]);
                win  = c;
            end
        end
        return win;
    endfunction

    task automatic model_step();
        bit [2:0] ea;
        bit [2:0] da;
        ea = 3'b000;
        if (m_busy && req[m_ch] && !rst) ea[m_ch] = 1'b1;
        da = {ack2, ack1, ack0};
        if (da != 3'b000 && prev_ack == 3'b000) pkt_q.push_back(da[0] ? 0 : (da[1] ? 1 : 2));
        prev_ack = da;
        if (chk_en) begin
            chk("ack", 32'(da), 32'(ea));
            chk("val", 32'(oval), 32'(m_val));
            chk("data", odata, m_data);
            chk("id", 32'(oid), 32'(m_id));
            chk("stat0", 32'(st0), 32'(m_stat[0]));
            chk("stat1", 32'(st1), 32'(m_stat[1]));
            chk("stat2", 32'(st2), 32'(m_stat[2]));
        end
        if (rst) begin
            m_busy = 0; m_ch = 0; m_beats = 0; m_last = 2;
            m_val = 0; m_data = '0; m_id = 0;
            for (int c = 0; c < 3; c++) m_stat[c] = 0;
        end else begin
`ifdef MCDT_ARB_STATS_EN
            for (int c = 0; c < 3; c++) begin
                if (clr)                             m_stat[c] = 0;
                else if (ea[c] && m_stat[c] < SAT)   m_stat[c]++;
            end
`endif
            if (!m_busy) begin
                m_val = 0;
                if (req[0] || req[1] || req[2]) begin
                    m_ch = pick(); m_busy = 1; m_beats = 0;
                end
            end else if (ea[m_ch]) begin
                m_val = 1; m_data = din[m_ch]; m_id = m_ch;
                m_beats++;
                if (m_beats == PL) begin m_busy = 0; m_last = m_ch; end
            end else begin
                m_val = 0; m_busy = 0; m_last = m_ch;
            end
        end
    endtask

    task automatic step(); @(negedge clk); model_step(); endtask
    task automatic adv();  @(posedge clk); #1; endtask
    task automatic cyc();  step(); adv(); endtask

    task automatic do_reset();
        rst = 1'b1; cyc(); rst = 1'b0;
    endtask

    task automatic set_req(input logic [2:0] r);
        for (int c = 0; c < 3; c++) req[c] = r[c];
    endtask

    typedef struct {
        logic [2:0]  req;
        logic [31:0] d1;
        logic [2:0]  ack;
        logic        val;
        logic [1:0]  id;
        logic [31:0] data;
    } vec_t;

    vec_t tv [0:7];
    int   cnt_a, cnt_b;

    initial begin
        tv[0] = '{3'b010, 32'hC0010000, 3'b000, 1'b0, 2'd0, 32'h00000000};
        tv[1] = '{3'b010, 32'hC0010000, 3'b010, 1'b0, 2'd0, 32'h00000000};
        tv[2] = '{3'b010, 32'hC0010001, 3'b010, 1'b1, 2'd1, 32'hC0010000};
        tv[3] = '{3'b010, 32'hC0010002, 3'b010, 1'b1, 2'd1, 32'hC0010001};
        tv[4] = '{3'b010, 32'hC0010003, 3'b010, 1'b1, 2'd1, 32'hC0010002};
        tv[5] = '{3'b010, 32'hC0010004, 3'b000, 1'b1, 2'd1, 32'hC0010003};
        tv[6] = '{3'b010, 32'hC0010004, 3'b010, 1'b0, 2'd1, 32'hC0010003};
        tv[7] = '{3'b010, 32'hC0010005, 3'b010, 1'b1, 2'd1, 32'hC0010004};

        rst = 1'b1; clr = 1'b0;
        for (int c = 0; c < 3; c++) begin req[c] = 1'b0; din[c] = '0; pr[c] = 2'd0; end
        #1;
        cyc();
        chk_en = 1'b1;
        cyc();
        rst = 1'b0;

        // Quiet after reset.
        cnt_a = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (oval || ack0 || ack1 || ack2) cnt_a++;
            adv();
        end
        chk("idle_quiet", 32'(cnt_a), 32'd0);

        // Directed table: ch1 alone, prio 0.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_req(tv[i].req);
            din[1] = tv[i].d1;
            step();
            chk($sformatf("tv%0d_ack", i), 32'({ack2, ack1, ack0}), 32'(tv[i].ack));
            chk($sformatf("tv%0d_val", i), 32'(oval), 32'(tv[i].val));
            chk($sformatf("tv%0d_id", i), 32'(oid), 32'(tv[i].id));
            chk($sformatf("tv%0d_data", i), odata, tv[i].data);
            adv();
        end

        // All requesting at equal priority: round-robin 0,1,2,0,1,2.
        set_req(3'b000); do_reset();
        pkt_q.delete();
        set_req(3'b111);
        for (int i = 0; i < 32; i++) begin
            for (int c = 0; c < 3; c++) din[c] = $urandom;
            cyc();
        end
        chk("rr_len", 32'(pkt_q.size()), 32'd7);
        for (int i = 0; i < 6 && i < pkt_q.size(); i++)
            chk($sformatf("rr_order%0d", i), 32'(pkt_q[i]), 32'(i % 3));

        // ch2 highest priority starves the others; then ch0/ch1 alternate.
        set_req(3'b000); do_reset();
        set_req(3'b111); pr[0] = 2'd1; pr[1] = 2'd1; pr[2] = 2'd3;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (ack0 || ack1) cnt_a++;
            if (ack2) cnt_b++;
            adv();
        end
        chk("prio_starve", 32'(cnt_a), 32'd0);
        chk("prio_ch2_beats", 32'(cnt_b), 32'd24);
        pr[2] = 2'd0;
        pkt_q.delete();
        for (int i = 0; i < 20; i++) cyc();
        chk("alt_len", 32'(pkt_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < pkt_q.size(); i++)
            chk($sformatf("alt_order%0d", i), 32'(pkt_q[i]), 32'(i % 2));

        // ch0 drops its request after two beats; ch1 follows.
        pr[0] = 2'd0; pr[1] = 2'd0;
        set_req(3'b000); do_reset();
        pkt_q.delete();
        set_req(3'b011);
        cnt_a = 0;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) req[0] = 1'b0;
            step();
            if (oval && oid == 2'd0) cnt_a++;
            adv();
        end
        chk("drop_beats", 32'(cnt_a), 32'd2);
        chk("drop_next", 32'(pkt_q.size() > 1 ? pkt_q[1] : 9), 32'd1);

        // Reset in the middle of the ch1 packet.
        rst = 1'b1; cyc(); rst = 1'b0;
        req[0] = 1'b1;
        pkt_q.delete();
        step();
        chk("rst_val", 32'(oval), 32'd0);
        chk("rst_ack", 32'({ack2, ack1, ack0}), 32'd0);
        adv();
        for (int i = 0; i < 3; i++) cyc();
        chk("rst_first", 32'(pkt_q.size() > 0 ? pkt_q[0] : 9), 32'd0);

        // Beat counters: saturation, then clear concurrent with a pop.
        set_req(3'b000); do_reset();
        set_req(3'b001);
        for (int i = 0; i < 30; i++) cyc();
`ifdef MCDT_ARB_STATS_EN
        chk("stat_sat", 32'(st0), 32'(SAT));
`else
        chk("stat_off", 32'(st0), 32'd0);
`endif
        cyc(); cyc();
        clr = 1'b1;
        step();
        chk("clr_with_ack", 32'(ack0), 32'd1);
        adv();
        clr = 1'b0;
        step();
        chk("stat_clr", 32'(st0), 32'd0);
        adv();

        // Randomized traffic against the model.
        set_req(3'b000); do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            clr = ($urandom_range(0, 24) == 0);
            for (int c = 0; c < 3; c++) begin
                req[c] = ($urandom_range(0, 3) != 0);
                din[c] = $urandom;
                if ($urandom_range(0, 9) == 0) pr[c] = 2'($urandom_range(0, 3));
            end
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mcdt_arbiter.md
Name: mcdt_arbiter

Overview:
- Arbitration and sequencing stage of the multi-channel data transfer (MCDT) path.
- Takes requests from three channel slave FIFOs and grants one channel at a time, for a packet of up to PKT_LEN beats.
- Drives the merged output stream mcdt_data_o / mcdt_val_o / mcdt_id_o.
- Selection is by 2-bit programmable priority, with round-robin tie-break among equal priorities.

Parameters:
- DATA_W, 32, width of channel and output data.
- PKT_LEN, 4, maximum beats per grant. Legal range 1..16.
- CNT_W, 16, width of per-channel beat counters (optional feature only).

Ports:
- clk_i  in  1  clock; all logic on posedge.
- rst_i  in  1  synchronous reset, active-high.
- slv0_req_i / slv1_req_i / slv2_req_i  in  1 each  channel has data (FIFO non-empty).
- slv0_data_i / slv1_data_i / slv2_data_i  in  DATA_W each  head-of-FIFO data.
- slv0_prio_i / slv1_prio_i / slv2_prio_i  in  2 each  channel priority; 3 is highest.
- slv0_ack_o / slv1_ack_o / slv2_ack_o  out  1 each  pop strobe; data consumed this cycle.
- mcdt_data_o  out  DATA_W  merged output data.
- mcdt_val_o  out  1  output beat valid.
- mcdt_id_o  out  2  source channel of the beat (0..2).
- stat_clr_i  in  1  clear beat counters.
- stat0_cnt_o / stat1_cnt_o / stat2_cnt_o  out  CNT_W each  beats forwarded per channel.

Behaviour:
- Reset (rst_i=1 at posedge):
  - state=IDLE, grant_q=0, beat_cnt=0, last_q=2 (so ch0 is first in round-robin order).
  - mcdt_data_o=0, mcdt_val_o=0, mcdt_id_o=0, all ackX_o=0, stat counters=0.
  - Reset mid-packet aborts the packet; no ack in the reset cycle.
- States: IDLE, XFER.
- IDLE:
  - ackX_o=0.
  - If any reqX: the winner is the highest prio among requesting channels.
  - Ties are resolved by scanning from (last_q+1) mod 3 upward with wrap 2->0.
  - Next cycle: grant_q=winner, beat_cnt=0, state=XFER.
  - Arbitration costs exactly one bubble cycle per packet.
- XFER:
  - ack_{grant_q}_o = req_{grant_q} (combinational). All other acks are 0.
  - On ack: next cycle mcdt_data_o=that channel's data, mcdt_id_o=grant_q, mcdt_val_o=1, beat_cnt+1.
  - Without ack: next cycle mcdt_val_o=0; mcdt_data_o and mcdt_id_o hold their previous values.
  - Exit to IDLE, with last_q=grant_q, when (ack and beat_cnt==PKT_LEN-1) or req_{grant_q}=0.
  - On a req drop the packet ends early; the cycle where req is low has no ack and no beat.
- Latency: ack at cycle N -> mcdt_val_o=1 at cycle N+1. At most one ack per cycle.
- Priority inputs are sampled only in IDLE. Changes during XFER affect the next arbitration only.
- PKT_LEN=1: every beat is followed by an IDLE cycle, so peak throughput is 1 beat per 2 cycles.
- Full throughput within a packet: PKT_LEN beats on consecutive cycles.
- No backpressure on the output: the downstream side must always accept mcdt_val_o.
- Requests arriving during XFER wait. There is no preemption, including by higher priority.
- beat_cnt width is 4 bits and never wraps, because of the exit condition.

Optional Feature:
- Macro: MCDT_ARB_STATS_EN.
- When defined:
  - statX_cnt_o increments on each cycle slvX_ack_o=1 and saturates at 2^CNT_W-1.
  - stat_clr_i=1 zeroes all counters at the next posedge; clear wins over a simultaneous increment.
- When undefined:
  - statX_cnt_o are tied to 0 and stat_clr_i is ignored. No counter flops are built.

Test Plan:
- Reset, then no reqs for 20 cycles -> mcdt_val_o=0, all acks 0, state stays IDLE.
- Only ch1 requesting continuously, prio=0, PKT_LEN=4, data 0xC0010000+n:
  - 1 bubble, then ack1 for 4 consecutive cycles.
  - mcdt_val_o high for 4 cycles, 1 cycle later, with mcdt_id_o=1 and data 0xC0010000..03.
  - Bubble, repeat.
- All three requesting continuously, all prio=0 -> packet order ch0, ch1, ch2, ch0...; each packet is 4 beats with 1 bubble between packets.
- All requesting, ch2 prio=3, others prio=1 -> ch2 wins every arbitration, and ch0/ch1 never ack. Then set ch2 prio=0 -> ch0 and ch1 alternate.
- ch0 drops req after 2 beats -> packet ends, 2 outputs with id=0, then arbitration resumes with ch1 next. Assert rst_i mid-packet -> next cycle mcdt_val_o=0, acks 0, and ch0 is first again after reset.
- With MCDT_ARB_STATS_EN and CNT_W=4:
  - 20 ch0 beats -> stat0_cnt_o=15 (saturated).
  - stat_clr_i pulse concurrent with an ack -> stat0_cnt_o=0.
  - Without the macro: stat0_cnt_o=0 throughout.
